bcd_adder8_ctrl: RTL and testbench

Control and datapath for the 8-bit (2-digit) BCD adder on the DE1. It sequences operand entry (A, B, carry-in) from the slide switches using an Enter key. It validates the BCD digits, performs the add, and holds the 12-bit result. It drives the 3-bit out_mux_sel code and the RSLT bus consumed by the display output mux, which feeds SEG7_4.

---
 rtl/bcd_adder8_pkg.sv | 48 ++++
 rtl/bcd_digit_add.sv | 21 ++
 rtl/bcd_adder8_ctrl.sv | 134 +++++++++++++
 tb/tb_bcd_adder8_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_adder8_pkg.sv
// Shared constants for the 2-digit BCD adder: display select codes, FSM states, digit limit.
// Latency: none (declarations only).
// Backpressure: none.
package bcd_adder8_pkg;

  // Display mux select codes, also used by the output mux
  localparam logic [2:0] SHOWA     = 3'd0;
  localparam logic [2:0] SHOWB     = 3'd1;
  localparam logic [2:0] SHOWCIN   = 3'd2;
  localparam logic [2:0] SHOWRSLT  = 3'd3;
  localparam logic [2:0] SHOWZEROS = 3'd4;
  localparam logic [2:0] SHOWBLNKS = 3'd5;
  localparam logic [2:0] SHOWERR   = 3'd6;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [2:0] {
    S_BLANK,
    S_GETA,
    S_GETB,
    S_GETCIN,
    S_ADD,
    S_SHOW,
    S_ERR
  } state_t;

  // Moore display code for each state
  function automatic logic [2:0] sel_for(input state_t s);
    logic [2:0] r;
    case (s)
      S_BLANK:  r = SHOWBLNKS;
      S_GETA:   r = SHOWA;
      S_GETB:   r = SHOWB;
      S_GETCIN: r = SHOWCIN;
      S_ADD:    r = SHOWZEROS;
      S_SHOW:   r = SHOWRSLT;
      S_ERR:    r = SHOWERR;
      default:  r = SHOWBLNKS;
    endcase
    return r;
  endfunction

  // True when both nibbles of a switch byte are legal BCD digits
  function automatic logic bcd_byte_ok(input logic [7:0] v);
    return (v[7:4] <= BCD_MAX_DIGIT) && (v[3:0] <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit adder: a + b + cin with decimal correction, producing a digit and carry.
// Latency: purely combinational.
// Backpressure: none.
module bcd_digit_add
  import bcd_adder8_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] s;

  // Binary sum is at most 19, so 5 bits hold it; above 9 add 6 to wrap into the next decade
  assign s    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign cout = (s > {1'b0, BCD_MAX_DIGIT});
  assign sum  = cout ? (s[3:0] + 4'd6) : s[3:0];

endmodule

// File: rtl/bcd_adder8_ctrl.sv
// Sequences A/B/Cin entry from switches on Enter, validates BCD digits, adds, holds 12-bit result.
// Latency: RSLT and done appear one S_ADD cycle after the edge that latches Cin.
// Backpressure: none; Enter rising edges advance one state, SW[9] aborts back to A entry.
module bcd_adder8_ctrl #(
  parameter int BLANK_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  SW,
  input  logic        enter,
  output logic [2:0]  out_mux_sel,
  output logic [11:0] RSLT,
  output logic        done
);

  import bcd_adder8_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic             enter_q;
  logic             enter_rise;
  logic             abort;
  logic             digits_ok;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       a_reg;
  logic [7:0]       b_reg;
  logic             cin_reg;
  logic [3:0]       ones;
  logic [3:0]       tens;
  logic             c0;
  logic             c1;
  logic             sw_unused;

  // SW[8] has no function on this board
  assign sw_unused  = SW[8];

  assign enter_rise = enter & ~enter_q;
  assign abort      = SW[9] & (state != S_BLANK);
  assign digits_ok  = bcd_byte_ok(SW[7:0]);

  // Ones digit first; its carry feeds the tens digit in the same cycle
  bcd_digit_add u_ones (
    .a    (a_reg[3:0]),
    .b    (b_reg[3:0]),
    .cin  (cin_reg),
    .sum  (ones),
    .cout (c0)
  );

  bcd_digit_add u_tens (
    .a    (a_reg[7:4]),
    .b    (b_reg[7:4]),
    .cin  (c0),
    .sum  (tens),
    .cout (c1)
  );

  // Next-state decode; abort outranks Enter in every state but the blank interval
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = S_GETA;
    end else begin
      case (state)
        S_BLANK:  if (cnt == CNT_LAST) next_state = S_GETA;
        S_GETA:   if (enter_rise) next_state = digits_ok ? S_GETB : S_ERR;
        S_GETB:   if (enter_rise) next_state = digits_ok ? S_GETCIN : S_ERR;
        S_GETCIN: if (enter_rise) next_state = S_ADD;
        S_ADD:    next_state = S_SHOW;
        S_SHOW:   if (enter_rise) next_state = S_GETA;
        S_ERR:    if (enter_rise) next_state = S_GETA;
        default:  next_state = S_BLANK;
      endcase
    end
  end

  // State register; the display code is decoded from next_state so it moves with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_BLANK;
      out_mux_sel <= SHOWBLNKS;
      enter_q     <= 1'b0;
    end else begin
      state       <= next_state;
      out_mux_sel <= sel_for(next_state);
      enter_q     <= enter;
    end
  end

  // Blank-interval counter, held at zero outside the blank state
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == S_BLANK && cnt != CNT_LAST) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Operand capture on accepted Enter edges; an error discards partial operands
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
      cin_reg <= 1'b0;
    end else if (state == S_ERR) begin
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
    end else if (!abort && enter_rise) begin
      if (state == S_GETA && digits_ok) a_reg <= SW[7:0];
      if (state == S_GETB && digits_ok) b_reg <= SW[7:0];
      if (state == S_GETCIN)            cin_reg <= SW[0];
    end
  end

  // Result register and done pulse, updated only when the add cycle completes
  always_ff @(posedge clk) begin
    if (reset) begin
      RSLT <= 12'h000;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_ADD && !abort) begin
        RSLT <= {3'b000, c1, tens, ones};
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_adder8_ctrl.sv
// Bench for bcd_adder8_ctrl: directed sequences with literal results, then random traffic vs a decimal model.
// Latency: model predicts outputs after every clock edge.
// Backpressure: n/a.
module tb_bcd_adder8_ctrl;

  localparam int BLANK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  SW;
  logic        enter;
  logic [2:0]  out_mux_sel;
  logic [11:0] RSLT;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_adder8_ctrl #(.BLANK_CYCLES(BLANK), .CNT_W(26)) dut (
    .clk         (clk),
    .reset       (reset),
    .SW          (SW),
    .enter       (enter),
    .out_mux_sel (out_mux_sel),
    .RSLT        (RSLT),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (decimal arithmetic, display-code phases) ----------------
  logic [2:0]  m_sel = 3'd5;
  logic [11:0] m_rslt = 12'h000;
  logic        m_done = 1'b0;
  int          m_cnt = 0;
  logic        m_eq = 1'b0;
  logic [7:0]  m_a = 8'h00, m_b = 8'h00;
  logic        m_c = 1'b0;
  logic        m_rise;
  bit          chk_en = 1'b0;
  int          m_total;

  function automatic bit ok_byte(input logic [7:0] v);
    return (v[7:4] < 4'd10) && (v[3:0] < 4'd10);
  endfunction

  function automatic int dec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  always @(posedge clk) begin
    m_rise = enter && !m_eq;
    m_done = 1'b0;
    if (reset) begin
      m_sel  = 3'd5;
      m_rslt = 12'h000;
      m_cnt  = 0;
      m_eq   = 1'b0;
      chk_en = 1'b1;
    end else begin
      m_eq = enter;
      if (m_sel != 3'd5 && SW[9]) begin
        m_sel = 3'd0;
      end else begin
        case (m_sel)
          3'd5: if (m_cnt == BLANK - 1) begin m_sel = 3'd0; m_cnt = 0; end
                else m_cnt++;
          3'd0: if (m_rise) begin
                  if (ok_byte(SW[7:0])) begin m_a = SW[7:0]; m_sel = 3'd1; end
                  else m_sel = 3'd6;
                end
          3'd1: if (m_rise) begin
                  if (ok_byte(SW[7:0])) begin m_b = SW[7:0]; m_sel = 3'd2; end
                  else m_sel = 3'd6;
                end
          3'd2: if (m_rise) begin m_c = SW[0]; m_sel = 3'd4; end
          3'd4: begin
                  m_total = dec(m_a) + dec(m_b) + int'(m_c);
                  m_rslt  = {4'(m_total / 100), 4'((m_total / 10) % 10), 4'(m_total % 10)};
                  m_done  = 1'b1;
                  m_sel   = 3'd3;
                end
          default: if (m_rise) m_sel = 3'd0;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("sel", {9'b0, out_mux_sel}, {9'b0, m_sel});
      check("rslt", RSLT, m_rslt);
      check("done", {11'b0, done}, {11'b0, m_done});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse Enter for one cycle, report display code right after the accepting edge, leave one low cycle
  task automatic press(input logic [9:0] v, output logic [2:0] s);
    SW = v;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    @(negedge clk);
    s = out_mux_sel;
    tick();
  endtask

  logic [2:0] s;

  initial begin
    reset = 1'b1;
    SW    = 10'h000;
    enter = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // blank interval after reset
    for (int i = 0; i < BLANK; i++) begin
      @(negedge clk);
      check("blank_sel", {9'b0, out_mux_sel}, 12'd5);
      check("blank_done", {11'b0, done}, 12'd0);
    end
    @(negedge clk);
    check("geta_after_blank", {9'b0, out_mux_sel}, 12'd0);
    check("rslt_reset", RSLT, 12'h000);
    tick();

    // 47 + 38 + 1 = 86
    press(10'h047, s); check("sel_b", {9'b0, s}, 12'd1);
    press(10'h038, s); check("sel_cin", {9'b0, s}, 12'd2);
    press(10'h001, s); check("sel_add", {9'b0, s}, 12'd4);
    @(negedge clk);
    check("sel_show", {9'b0, out_mux_sel}, 12'd3);
    check("rslt_086", RSLT, 12'h086);
    check("done_pulse", {11'b0, done}, 12'd1);
    @(negedge clk);
    check("done_once", {11'b0, done}, 12'd0);
    tick();

    // 99 + 99 + 1 = 199, then 00 + 00 + 0
    press(10'h000, s); check("show_to_a", {9'b0, s}, 12'd0);
    press(10'h099, s);
    press(10'h099, s);
    press(10'h001, s);
    @(negedge clk);
    check("rslt_199", RSLT, 12'h199);
    tick();
    press(10'h000, s);
    press(10'h000, s);
    press(10'h000, s);
    press(10'h000, s);
    @(negedge clk);
    check("rslt_000", RSLT, 12'h000);
    check("done_000", {11'b0, done}, 12'd1);
    tick();

    // invalid digit, Enter held high
    press(10'h000, s);
    SW = 10'h03A;
    enter = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("err_hold", {9'b0, out_mux_sel}, 12'd6);
    end
    tick();
    enter = 1'b0;
    tick();
    press(10'h000, s); check("err_to_a", {9'b0, s}, 12'd0);

    // 12 + 34 + 0 = 46, then abort in B entry together with an Enter edge
    press(10'h012, s);
    press(10'h034, s);
    press(10'h000, s);
    @(negedge clk);
    check("rslt_046", RSLT, 12'h046);
    tick();
    press(10'h000, s);
    press(10'h012, s); check("in_getb", {9'b0, s}, 12'd1);
    SW = 10'h255;
    enter = 1'b1;
    tick();
    @(negedge clk);
    check("abort_sel", {9'b0, out_mux_sel}, 12'd0);
    check("abort_rslt", RSLT, 12'h046);
    tick();
    SW = 10'h000;
    enter = 1'b0;
    tick();

    // reset while waiting for Cin
    press(10'h012, s);
    press(10'h034, s); check("in_getcin", {9'b0, s}, 12'd2);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("rst_sel", {9'b0, out_mux_sel}, 12'd5);
    check("rst_rslt", RSLT, 12'h000);
    tick();
    reset = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      SW[3:0] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      SW[7:4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      SW[8]   = 1'($urandom_range(0, 1));
      SW[9]   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) enter = ~enter;
      reset   = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
